// File: rtl/serial_in_word_assembler.sv
// Serial-to-parallel word assembler feeding the PIPO register stage, with a one-word hold buffer.
// Optional build macro PARITY_CHECK_EN adds an even-parity bit after each data word.
module serial_in_word_assembler #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Serial_Data_In,
  input  logic                  Serial_Valid_In,
  input  logic                  Frame_Start_In,
  input  logic                  Hold_In,
  input  logic                  Error_Clear_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
  output logic                  Load_Data_Signal_Out,
  output logic                  Busy_Out,
  output logic                  Overrun_Error_Out,
  output logic                  Parity_Error_Out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pending_q, pending_d;
  logic                  load_q, load_d;
  logic                  busy_q;
  logic                  ovr_q, ovr_d;
  logic                  accept_s;
  logic                  word_done_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  release_s;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr, input logic b);
    if (MSB_FIRST) begin
      return {sr[DATA_WIDTH-2:0], b};
    end else begin
      return {b, sr[DATA_WIDTH-1:1]};
    end
  endfunction

`ifdef PARITY_CHECK_EN
  logic par_q, par_d;
  logic par_fail_s;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_ok(input logic [DATA_WIDTH-1:0] d, input logic p);
    return ((^d) ^ p) == 1'b0;
  endfunction
`endif

  assign accept_s  = Enable_In & Serial_Valid_In;
  assign release_s = pending_q & ~Hold_In & Enable_In & ~load_q;

  // State and datapath registers.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      pending_q <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      load_q    <= load_d;
      busy_q    <= (state_d != ST_IDLE);
      ovr_q     <= ovr_d;
`ifdef PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  // Next-state: framing, shifting and word-completion detection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    word_done_s = 1'b0;
    word_s      = sr_q;
`ifdef PARITY_CHECK_EN
    par_fail_s  = 1'b0;
`endif
    if (accept_s && Frame_Start_In) begin
      // A frame start always restarts assembly, even mid-frame.
      state_d = ST_SHIFT;
      cnt_d   = CW'(1);
      sr_d    = shift_in({DATA_WIDTH{1'b0}}, Serial_Data_In);
    end else if (accept_s) begin
      case (state_q)
        ST_SHIFT: begin
          sr_d = shift_in(sr_q, Serial_Data_In);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state_d = ST_PARITY;
            cnt_d   = CW'(DATA_WIDTH);
`else
            state_d     = ST_IDLE;
            cnt_d       = '0;
            word_done_s = 1'b1;
            word_s      = sr_d;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_PARITY: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
`ifdef PARITY_CHECK_EN
          if (parity_ok(sr_q, Serial_Data_In)) begin
            word_done_s = 1'b1;
          end else begin
            par_fail_s = 1'b1;
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output side: hold buffer, strobe generation and sticky error flags.
  always_comb begin
    data_d    = data_q;
    pending_d = pending_q;
    load_d    = 1'b0;
    ovr_d     = Error_Clear_In ? 1'b0 : ovr_q;
    if (release_s) begin
      load_d    = 1'b1;
      pending_d = 1'b0;
    end else begin
      load_d    = 1'b0;
    end
    if (word_done_s) begin
      if (pending_q) begin
        ovr_d = 1'b1;
      end else if (Hold_In || load_q) begin
        // Deferring behind a live strobe keeps strobes at least one cycle apart.
        data_d    = word_s;
        pending_d = 1'b1;
      end else begin
        data_d = word_s;
        load_d = 1'b1;
      end
    end else begin
      data_d = data_q;
    end
  end

`ifdef PARITY_CHECK_EN
  // Sticky parity flag; a new failure wins over a same-cycle clear.
  always_comb begin
    par_d = Error_Clear_In ? 1'b0 : par_q;
    if (par_fail_s) begin
      par_d = 1'b1;
    end else begin
      par_d = par_d;
    end
  end

  assign Parity_Error_Out = par_q;
`else
  assign Parity_Error_Out = 1'b0;
`endif

  assign Parallel_Data_Out    = data_q;
  assign Load_Data_Signal_Out = load_q;
  assign Busy_Out             = busy_q;
  assign Overrun_Error_Out    = ovr_q;

endmodule
